// File: rtl/mega_mux_if.sv
// Handshake bundle between N input channels and the single registered output of mega_mux_arbiter.
// The master side drives the channels and downstream ready. The slave side is the arbiter.
interface mega_mux_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SELW     = $clog2(CHANNELS)
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [SELW-1:0]           sel;
    logic                      mode;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SELW-1:0]           out_chan;

    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );

    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );
endinterface

// File: rtl/mega_mux_arbiter.sv
// Registered N:1 channel selector with valid/ready handshake and a one-entry output register.
// Define MEGAMUX_RR_EN to build the round-robin grant mode (mode=1) and its last pointer.
module mega_mux_arbiter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SELW     = $clog2(CHANNELS)
) (
    input logic       clk,
    input logic       reset,
    mega_mux_if.slave bus
);
    typedef enum logic {StEmpty, StFull} state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [SELW-1:0]     chan_q, chan_d;
    logic [SELW-1:0]     grant;
    logic                grant_valid;
    logic                fixed_valid;
    logic                load;
    logic [WIDTH-1:0]    grant_data;
    logic [CHANNELS-1:0] in_ready;

    // Compare against every legal index so an out-of-range sel simply matches nothing.
    always_comb begin
        fixed_valid = 1'b0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (bus.sel == SELW'(k)) fixed_valid = bus.in_valid[k];
        end
    end

`ifdef MEGAMUX_RR_EN
    logic [SELW-1:0] last_q, last_d;
    logic [SELW-1:0] rr_grant;
    logic            rr_found;
    logic            rr_active;
    int unsigned     idx;

    assign rr_active = bus.mode;

    // Scan last+1, last+2, ... wrapping at CHANNELS rather than 2**SELW.
    always_comb begin
        rr_grant = last_q;
        rr_found = 1'b0;
        idx      = 0;
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
            idx = 32'(last_q) + i;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!rr_found && bus.in_valid[idx[SELW-1:0]]) begin
                rr_found = 1'b1;
                rr_grant = idx[SELW-1:0];
            end
        end
    end

    assign grant       = rr_active ? rr_grant : bus.sel;
    assign grant_valid = rr_active ? rr_found : fixed_valid;
    assign last_d      = (rr_active && load) ? grant : last_q;

    always_ff @(posedge clk) begin
        if (reset) last_q <= SELW'(CHANNELS - 1);
        else       last_q <= last_d;
    end
`else
    logic unused_mode;

    assign unused_mode = bus.mode;
    assign grant       = bus.sel;
    assign grant_valid = fixed_valid;
`endif

    always_comb begin
        grant_data = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (grant == SELW'(k)) grant_data = bus.in_data[k*WIDTH +: WIDTH];
        end
    end

    assign load = !reset && ((state_q == StEmpty) || bus.out_ready) && grant_valid;

    always_comb begin
        in_ready = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (load && (grant == SELW'(k))) in_ready[k] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        chan_d  = chan_q;
        case (state_q)
            StEmpty: if (load) state_d = StFull;
            StFull: begin
                if (load)               state_d = StFull;
                else if (bus.out_ready) state_d = StEmpty;
            end
            default: state_d = StEmpty;
        endcase
        if (load) begin
            data_d = grant_data;
            chan_d = grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
            data_q  <= '0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
    assign bus.out_valid = (state_q == StFull);
endmodule
